// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, decoder branch encodings and
// the fetch-stage state type.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 15;
  localparam int unsigned CPU_DATA_W = 16;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_REL  = 2'b01;
  localparam logic [1:0] BR_JUMP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_WAIT  = 2'b10,
    ST_EXEC  = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: sequential increment, signed relative branch or
// absolute jump, all wrapping modulo 2^ADDR_W.
module pc_next_logic
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = CPU_ADDR_W,
  parameter int unsigned DATA_W = CPU_DATA_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        branch,
  input  logic [ADDR_W-1:0] pc_change,
  input  logic [DATA_W-1:0] jump_target,
  output logic [ADDR_W-1:0] next_pc
);

  // Two's-complement offset added at PC width gives the signed wrap for free.
  always_comb begin
    next_pc = pc + ADDR_W'(1);
    case (branch)
      BR_NONE: next_pc = pc + ADDR_W'(1);
      BR_REL:  next_pc = pc + pc_change;
      BR_JUMP: next_pc = jump_target[ADDR_W-1:0];
      default: next_pc = pc + ADDR_W'(1);
    endcase
  end

  if (DATA_W > ADDR_W) begin : g_jump_hi
    logic unused_jump_hi;
    assign unused_jump_hi = ^jump_target[DATA_W-1:ADDR_W];
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and instruction fetch stage: request/valid memory
// handshake, instruction register, next-PC update and fetch timeout/retry.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = CPU_ADDR_W,
  parameter int unsigned       DATA_W   = CPU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              exec_stall,
  input  logic [1:0]        branch,
  input  logic [ADDR_W-1:0] pc_change,
  input  logic [DATA_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  localparam int unsigned        CNT_W    = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_WAIT - 1);

  fetch_state_t      state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] next_pc;
  logic              accept;
  logic              timeout;
  logic              retire;

  pc_next_logic #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pc_next (
    .pc          (pc),
    .branch      (branch),
    .pc_change   (pc_change),
    .jump_target (jump_target),
    .next_pc     (next_pc)
  );

  // A valid response on the final wait cycle takes priority over the timeout.
  assign accept  = (state == ST_WAIT) && mem_valid;
  assign timeout = (state == ST_WAIT) && !mem_valid && (wait_cnt == CNT_LAST);
  assign retire  = (state == ST_EXEC) && !exec_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (accept) begin
          state_nxt = ST_EXEC;
        end else if (timeout) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (retire) begin
          state_nxt = enable ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd    = (state == ST_FETCH);
    fetch_err = timeout;
  end

  assign mem_addr = pc;

  // PC only moves on retirement, so mem_addr stays stable across FETCH/WAIT
  // and a timeout retry naturally re-requests the same address.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (accept) begin
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
          end else if (!timeout) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (retire) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural memory with programmable
// latency and an architectural next-PC model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [14:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_stall;
  logic [1:0]  branch;
  logic [14:0] pc_change;
  logic [15:0] jump_target;
  logic [14:0] pc;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:32767];
  bit          pend;
  logic [14:0] pend_addr;
  int          pend_cnt;
  int          mem_lat;

  fetch_unit #(
    .ADDR_W   (15),
    .DATA_W   (16),
    .RESET_PC (15'h0000),
    .MAX_WAIT (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_stall  (exec_stall),
    .branch      (branch),
    .pc_change   (pc_change),
    .jump_target (jump_target),
    .pc          (pc),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: memory sees a request at the edge and answers mem_lat cycles
  // later (mem_lat == 0 means never). Outputs are read 2 time units after the edge.
  task automatic tick();
    logic        req;
    logic [14:0] a;
    req = mem_rd;
    a   = mem_addr;
    @(posedge clk);
    #1;
    if (req) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_cnt  = mem_lat;
    end
    mem_valid = 1'b0;
    mem_rdata = 16'($urandom);
    if (pend && pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_valid = 1'b1;
        mem_rdata = mem[pend_addr];
        pend      = 1'b0;
      end
    end
    #1;
  endtask

  // Architectural next PC: signed offset arithmetic with explicit modulo.
  function automatic int model_next(int cur, int br, int off, int jt);
    int soff;
    soff = (off >= 16384) ? off - 32768 : off;
    case (br)
      1:       return ((cur + soff) % 32768 + 32768) % 32768;
      2:       return jt % 32768;
      default: return (cur + 1) % 32768;
    endcase
  endfunction

  // Stimulus only: wait for an executing instruction, apply a decision, retire it.
  task automatic exec_one(input int br, input int off, input int jt, input int st,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) return;
    branch      = 2'(br);
    pc_change   = 15'(off);
    jump_target = 16'(jt);
    exec_stall  = (st != 0);
    for (int s = 0; s < st; s++) tick();
    exec_stall = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (pc !== 15'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc); end
    checks++; if (mem_addr !== 15'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", mem_addr); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b expected 0", mem_rd); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h expected 0000", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_ivalid: got %b expected 0", instr_valid); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", fetch_err); end
  endtask

  task automatic test_first_fetch();
    mem[0]  = 16'h0123;
    mem_lat = 1;
    reset   = 1'b0;
    enable  = 1'b1;
    branch  = 2'b00;
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL ff_c0_rd: got %b expected 0", mem_rd); end
    tick();
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 15'h0000) begin errors++; $display("FAIL ff_c1_req: got rd=%b addr=%h expected rd=1 addr=0000", mem_rd, mem_addr); end
    tick();
    checks++; if (mem_rd !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL ff_c2_wait: got rd=%b iv=%b expected 0 0", mem_rd, instr_valid); end
    tick();
    checks++; if (instr !== 16'h0123 || instr_valid !== 1'b1) begin errors++; $display("FAIL ff_c3_instr: got %h iv=%b expected 0123 iv=1", instr, instr_valid); end
    checks++; if (pc !== 15'h0000) begin errors++; $display("FAIL ff_c3_pc: got %h expected 0000", pc); end
    tick();
    checks++; if (pc !== 15'h0001 || mem_rd !== 1'b1 || mem_addr !== 15'h0001) begin errors++; $display("FAIL ff_c4_next: got pc=%h rd=%b addr=%h expected pc=0001 rd=1 addr=0001", pc, mem_rd, mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ff_c4_ivalid: got %b expected 0", instr_valid); end
  endtask

  task automatic test_branches();
    bit ok;
    exec_one(2, 0, 10, 0, ok);
    checks++; if (!ok || pc !== 15'd10) begin errors++; $display("FAIL br_jump10: got pc=%h ok=%b expected 000a", pc, ok); end
    exec_one(1, 15'h7FFD, 0, 0, ok);
    checks++; if (!ok || pc !== 15'd7 || mem_addr !== 15'd7 || mem_rd !== 1'b1) begin errors++; $display("FAIL br_rel_neg3: got pc=%h addr=%h rd=%b expected 0007", pc, mem_addr, mem_rd); end
    exec_one(2, 0, 16'h7FFF, 0, ok);
    exec_one(0, 0, 0, 0, ok);
    checks++; if (!ok || pc !== 15'h0000) begin errors++; $display("FAIL br_wrap_inc: got %h expected 0000", pc); end
    exec_one(2, 0, 5, 0, ok);
    exec_one(2, 0, 16'h8040, 0, ok);
    checks++; if (!ok || pc !== 15'h0040) begin errors++; $display("FAIL br_jump_trunc: got %h expected 0040", pc); end
    exec_one(2, 0, 5, 0, ok);
    exec_one(3, 0, 0, 0, ok);
    checks++; if (!ok || pc !== 15'd6) begin errors++; $display("FAIL br_reserved: got %h expected 0006", pc); end
  endtask

  task automatic test_timeout();
    bit early_err;
    mem_lat = 0;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 15'd6) begin errors++; $display("FAIL to_start: got rd=%b addr=%h expected rd=1 addr=0006", mem_rd, mem_addr); end
    early_err = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8 && (fetch_err || mem_rd)) early_err = 1'b1;
    end
    checks++; if (early_err) begin errors++; $display("FAIL to_early: got early err/rd=1 expected 0"); end
    checks++; if (fetch_err !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL to_pulse: got err=%b rd=%b expected err=1 rd=0", fetch_err, mem_rd); end
    tick();
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 15'd6 || fetch_err !== 1'b0) begin errors++; $display("FAIL to_retry: got rd=%b addr=%h err=%b expected rd=1 addr=0006 err=0", mem_rd, mem_addr, fetch_err); end
    mem_lat = 8;
    early_err = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (fetch_err) early_err = 1'b1;
    end
    checks++; if (early_err || mem_valid !== 1'b1) begin errors++; $display("FAIL to_valid_wins: got err_seen=%b valid=%b expected 0 1", early_err, mem_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== mem[6]) begin errors++; $display("FAIL to_accept: got %h iv=%b expected %h iv=1", instr, instr_valid, mem[6]); end
  endtask

  task automatic test_stall();
    bit bad;
    branch     = 2'b00;
    exec_stall = 1'b1;
    bad        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (instr !== mem[6] || instr_valid !== 1'b1 || pc !== 15'd6 || mem_rd !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL stall_hold: got instr=%h iv=%b pc=%h rd=%b expected %h 1 0006 0", instr, instr_valid, pc, mem_rd, mem[6]); end
    exec_stall = 1'b0;
    tick();
    checks++; if (pc !== 15'd7 || mem_rd !== 1'b1) begin errors++; $display("FAIL stall_release: got pc=%h rd=%b expected 0007 1", pc, mem_rd); end
  endtask

  task automatic test_enable();
    bit bad;
    mem_lat = 1;
    tick();
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    pend = 1'b0;
    checks++; if (pc !== 15'h0 || mem_addr !== 15'h0 || instr !== 16'h0 || instr_valid !== 1'b0 || mem_rd !== 1'b0 || fetch_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_wait: got pc=%h addr=%h instr=%h iv=%b rd=%b err=%b expected all zero", pc, mem_addr, instr, instr_valid, mem_rd, fetch_err);
    end
    reset = 1'b0;
    bad   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_rd !== 1'b0 || instr_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL idle_hold: got spurious rd/ivalid expected none"); end
    enable = 1'b1;
    tick();
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 15'h0) begin errors++; $display("FAIL en_fetch: got rd=%b addr=%h expected 1 0000", mem_rd, mem_addr); end
    tick();
    enable = 1'b0;
    branch = 2'b00;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== mem[0]) begin errors++; $display("FAIL en_drop_exec: got %h iv=%b expected %h iv=1", instr, instr_valid, mem[0]); end
    tick();
    bad = (mem_rd !== 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_rd !== 1'b0 || pc !== 15'd1) bad = 1'b1;
    end
    checks++; if (bad || pc !== 15'd1) begin errors++; $display("FAIL en_drop_idle: got pc=%h rd=%b expected pc=0001 no rd", pc, mem_rd); end
  endtask

  task automatic test_random();
    int exp_pc, lat, br, off, jt, st, cnt;
    bit err_seen;
    reset = 1'b1;
    tick();
    pend   = 1'b0;
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    exp_pc = 0;
    for (int n = 0; n < 60; n++) begin
      lat     = $urandom_range(1, 8);
      mem_lat = lat;
      checks++; if (mem_rd !== 1'b1 || mem_addr !== 15'(exp_pc)) begin errors++; $display("FAIL rnd_req[%0d]: got rd=%b addr=%h expected rd=1 addr=%h", n, mem_rd, mem_addr, 15'(exp_pc)); end
      cnt      = 0;
      err_seen = 1'b0;
      while (!instr_valid && cnt < 20) begin
        tick();
        cnt++;
        if (fetch_err) err_seen = 1'b1;
      end
      checks++; if (cnt != lat + 1 || err_seen) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d cycles err=%b expected %0d err=0", n, cnt, err_seen, lat + 1); end
      checks++; if (instr !== mem[exp_pc] || pc !== 15'(exp_pc)) begin errors++; $display("FAIL rnd_instr[%0d]: got %h pc=%h expected %h pc=%h", n, instr, pc, mem[exp_pc], 15'(exp_pc)); end
      br          = $urandom_range(0, 3);
      off         = $urandom_range(0, 32767);
      jt          = $urandom_range(0, 65535);
      st          = $urandom_range(0, 3);
      branch      = 2'(br);
      pc_change   = 15'(off);
      jump_target = 16'(jt);
      exec_stall  = (st != 0);
      for (int s = 0; s < st; s++) tick();
      checks++; if (instr_valid !== 1'b1 || pc !== 15'(exp_pc)) begin errors++; $display("FAIL rnd_stall[%0d]: got iv=%b pc=%h expected 1 %h", n, instr_valid, pc, 15'(exp_pc)); end
      exec_stall = 1'b0;
      tick();
      exp_pc = model_next(exp_pc, br, off, jt);
      checks++; if (pc !== 15'(exp_pc)) begin errors++; $display("FAIL rnd_next_pc[%0d]: got %h expected %h (br=%0d off=%h jt=%h)", n, pc, 15'(exp_pc), br, off, jt); end
    end
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    mem_valid   = 1'b0;
    mem_rdata   = '0;
    exec_stall  = 1'b0;
    branch      = 2'b00;
    pc_change   = '0;
    jump_target = '0;
    pend        = 1'b0;
    pend_addr   = '0;
    pend_cnt    = 0;
    mem_lat     = 1;
    for (int a = 0; a < 32768; a++) mem[a] = 16'($urandom);
    test_reset();
    test_first_fetch();
    test_branches();
    test_timeout();
    test_stall();
    test_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage directly upstream of the instruction decoder/controller.
- Holds the PC, reads one 16-bit instruction per step from instruction memory over a request/valid handshake, and presents it in an instruction register to the decoder.
- Consumes the decoder's branch/PC_change decision to form the next PC.
- Provides a fetch timeout with retry.

Parameters:
- ADDR_W, 15, PC and instruction-address width (matches PC_change width)
- DATA_W, 16, instruction width
- RESET_PC, 0, PC value loaded on reset
- MAX_WAIT, 8, cycles allowed in WAIT for mem_valid before timeout (≥2)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  run request; 0 parks the unit in IDLE after the current instruction
- mem_addr  out  ADDR_W  instruction memory address
- mem_rd  out  1  one-cycle read request strobe
- mem_rdata  in  DATA_W  instruction word from memory
- mem_valid  in  1  mem_rdata valid this cycle
- instr  out  DATA_W  instruction register to decoder
- instr_valid  out  1  instr holds a fetched instruction being executed
- exec_stall  in  1  execute stage busy (e.g. load/store); hold current instruction
- branch  in  2  decoder decision: 00 none, 01 relative branch, 10 jump, 11 reserved
- pc_change  in  ADDR_W  signed PC offset from decoder (two's complement)
- jump_target  in  DATA_W  register value used as absolute jump address
- pc  out  ADDR_W  current PC
- fetch_err  out  1  one-cycle pulse on fetch timeout

Behaviour:
- Reset (sync, overrides everything, including mid-fetch):
  - pc=RESET_PC, mem_addr=RESET_PC, mem_rd=0, instr=16'h0000, instr_valid=0, fetch_err=0, wait counter=0, state=IDLE.
  - Any outstanding mem_valid after reset is ignored.
- States: IDLE, FETCH, WAIT, EXEC.
- IDLE:
  - All strobes 0.
  - enable=1 → FETCH next cycle.
- FETCH:
  - mem_rd=1 for exactly this cycle; mem_addr=pc; counter cleared.
  - → WAIT.
  - mem_valid in this cycle is ignored; minimum memory latency is 1 cycle.
- WAIT:
  - mem_rd=0; mem_addr stays at pc.
  - mem_valid=1: instr<=mem_rdata, instr_valid<=1, → EXEC.
  - Otherwise counter increments.
  - Counter reaches MAX_WAIT-1 without valid: fetch_err=1 for one cycle, → FETCH, retry the same pc; instr unchanged.
  - mem_valid arriving in the same cycle as the timeout wins: instruction accepted, no error.
- EXEC:
  - instr_valid=1; decoder inputs are sampled only here.
  - exec_stall=1: hold state, pc, instr.
  - exec_stall=0: pc<=next_pc, instr_valid<=0, → FETCH if enable else IDLE.
  - next_pc:
    - 00 → pc+1
    - 01 → pc+pc_change
    - 10 → jump_target[ADDR_W-1:0]
    - 11 → pc+1
  - All arithmetic modulo 2^ADDR_W, wrapping silently: 0x7FFF+1=0x0000; 0x0000+0x7FFF (=-1) → 0x7FFF.
- Throughput: 3 cycles per instruction with 1-cycle memory and no stall (FETCH, WAIT, EXEC).
- enable dropped in FETCH/WAIT: current fetch and execute complete, PC updates, then IDLE.
- instr retains the last instruction while in IDLE/FETCH/WAIT; only instr_valid qualifies it.

Decomposition:
- Shared package cpu_pkg holds:
  - branch encodings BR_NONE=2'b00, BR_REL=2'b01, BR_JUMP=2'b10
  - fetch state encoding (IDLE, FETCH, WAIT, EXEC)
  - ADDR_W/DATA_W defaults
- One natural sub-module: pc_next_logic, combinational next-PC mux/adder (pc, branch, pc_change, jump_target → next_pc).

Test Plan:
- Reset then enable=1, memory latency 1, mem[0]=16'h0123, branch=00: mem_rd pulses with mem_addr=0 in cycle 1; instr=0x0123 and instr_valid=1 in cycle 3; pc=1 in cycle 4; next mem_rd at cycle 4 with addr 1.
- pc=10, branch=01, pc_change=15'h7FFD (-3): next fetch address 7. With pc=0x7FFF, branch=00: next address 0x0000 (wrap).
- pc=5, branch=10, jump_target=16'h8040: next pc=0x0040 (upper bit dropped). branch=11 at pc=5 → pc=6.
- Memory never responds, MAX_WAIT=8: fetch_err pulses once 8 cycles after mem_rd; mem_rd re-pulses next cycle with the same address. Valid on the timeout cycle → no error, instruction accepted.
- exec_stall held 4 cycles in EXEC: instr, instr_valid=1, and pc constant; no mem_rd. PC advances the cycle after stall drops.
- Reset asserted during WAIT with mem_valid=1 on the same cycle: outputs return to reset values, instr=0, instr_valid=0. enable=0 at end of EXEC → IDLE, no further mem_rd.
